// File: rtl/steer_delay_ctrl.sv
// Steering-delay controller: shadow per-channel delays, atomic sample-aligned
// transfer to the delay lines, then a settle window of max(delay)+1 ticks.
module steer_delay_ctrl #(
   parameter int NUM_CH    = 8,
   parameter int DELAY_W   = 6,
   parameter int MAX_DELAY = 63,
   parameter int CH_W      = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sample_tick,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [CH_W-1:0]             cfg_ch,
   input  logic [DELAY_W-1:0]          cfg_delay,
   input  logic                        commit,
   output logic [NUM_CH*DELAY_W-1:0]   delay_out,
   output logic                        settling,
   output logic                        out_valid,
   output logic                        cfg_err
);

   typedef enum logic [1:0] {IDLE, ARMED, SETTLE} state_t;

   localparam logic [DELAY_W-1:0] MAX_L = DELAY_W'(MAX_DELAY);
   localparam logic [DELAY_W:0]   ONE_C = (DELAY_W+1)'(1);

   state_t                             state_q, state_d;
   logic [NUM_CH-1:0][DELAY_W-1:0]     shadow_q, shadow_d;
   logic [NUM_CH-1:0][DELAY_W-1:0]     active_q, active_d;
   logic [DELAY_W:0]                   cnt_q, cnt_d;
   logic                               primed_q, primed_d;
   logic                               settling_q, settling_d;
   logic                               err_q, err_d;

   logic                               wr_fire, ch_ok;
   logic [DELAY_W-1:0]                 wr_val, max_v;

   assign wr_fire = cfg_valid & cfg_ready;
   assign wr_val  = (cfg_delay > MAX_L) ? MAX_L : cfg_delay;

   // Shadow update; out-of-range channels match no slot and raise cfg_err.
   always_comb begin
      shadow_d = shadow_q;
      ch_ok    = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (cfg_ch == CH_W'(k)) begin
            ch_ok = 1'b1;
            if (wr_fire) shadow_d[k] = wr_val;
         end
      end
      err_d = wr_fire & ~ch_ok;
   end

   always_comb begin
      max_v = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (shadow_q[k] > max_v) max_v = shadow_q[k];
   end

   // settling is its own flop so it stays high across a re-commit from SETTLE.
   always_comb begin
      state_d    = state_q;
      active_d   = active_q;
      cnt_d      = cnt_q;
      primed_d   = primed_q;
      settling_d = settling_q;
      cfg_ready  = (state_q != ARMED);
      case (state_q)
         IDLE: begin
            if (commit) state_d = ARMED;
         end
         ARMED: begin
            if (sample_tick) begin
               active_d   = shadow_q;
               cnt_d      = (DELAY_W+1)'(max_v) + ONE_C;
               settling_d = 1'b1;
               state_d    = SETTLE;
            end
         end
         SETTLE: begin
            if (sample_tick) cnt_d = cnt_q - ONE_C;
            if (commit) begin
               state_d = ARMED;
            end else if (sample_tick && cnt_q == ONE_C) begin
               state_d    = IDLE;
               primed_d   = 1'b1;
               settling_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shadow_q   <= '0;
         active_q   <= '0;
         cnt_q      <= '0;
         primed_q   <= 1'b0;
         settling_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         cnt_q      <= cnt_d;
         primed_q   <= primed_d;
         settling_q <= settling_d;
         err_q      <= err_d;
      end
   end

   assign delay_out = active_q;
   assign settling  = settling_q;
   assign out_valid = primed_q & ~settling_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_steer_delay_ctrl.sv
// Directed bench for steer_delay_ctrl; a second instance (6 channels,
// MAX_DELAY=40) shares the stimulus to cover clamping and invalid channels.
module tb_steer_delay_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample_tick = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [2:0]  cfg_ch = '0;
   logic [5:0]  cfg_delay = '0;
   logic        commit = 1'b0;
   logic        cfg_ready, settling, out_valid, cfg_err;
   logic [47:0] delay_out;
   logic        cfg_ready2, settling2, out_valid2, cfg_err2;
   logic [35:0] delay_out2;

   int total = 0;
   int bad   = 0;
   logic [5:0] s[8], a[8], s2[6], a2[6];

   always #5 clk = ~clk;

   steer_delay_ctrl #(.NUM_CH(8), .DELAY_W(6), .MAX_DELAY(63), .CH_W(3)) u_dut (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .commit(commit),
      .delay_out(delay_out), .settling(settling), .out_valid(out_valid), .cfg_err(cfg_err));

   steer_delay_ctrl #(.NUM_CH(6), .DELAY_W(6), .MAX_DELAY(40), .CH_W(3)) u_dut2 (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready2), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .commit(commit),
      .delay_out(delay_out2), .settling(settling2), .out_valid(out_valid2), .cfg_err(cfg_err2));

   function automatic logic [47:0] pk8();
      logic [47:0] r;
      for (int k = 0; k < 8; k++) r[k*6 +: 6] = a[k];
      return r;
   endfunction

   function automatic logic [35:0] pk6();
      logic [35:0] r;
      for (int k = 0; k < 6; k++) r[k*6 +: 6] = a2[k];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int ch, input int d, input bit with_commit = 1'b0);
      cfg_valid = 1'b1; cfg_ch = 3'(ch); cfg_delay = 6'(d); commit = with_commit;
      @(negedge clk);
      cfg_valid = 1'b0; commit = 1'b0;
      s[ch] = 6'((d > 63) ? 63 : d);
      if (ch < 6) s2[ch] = 6'((d > 40) ? 40 : d);
   endtask

   task automatic cmt();
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
   endtask

   task automatic tick(input int gap);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic xfer(input string tag);
      tick(0);
      for (int k = 0; k < 8; k++) a[k] = s[k];
      for (int k = 0; k < 6; k++) a2[k] = s2[k];
      chk({tag, "_dout"}, 64'(delay_out), 64'(pk8()));
      chk({tag, "_settling"}, 64'(settling), 64'(1));
      chk({tag, "_ovalid"}, 64'(out_valid), 64'(0));
   endtask

   task automatic settle(input int n, input int gap, input string tag);
      for (int i = 1; i <= n; i++) begin
         tick(0);
         if (i < n) chk({tag, "_hold"}, 64'(settling), 64'(1));
         repeat (gap) @(negedge clk);
      end
      chk({tag, "_end_settling"}, 64'(settling), 64'(0));
      chk({tag, "_end_ovalid"}, 64'(out_valid), 64'(1));
   endtask

   initial begin
      for (int k = 0; k < 8; k++) begin s[k] = '0; a[k] = '0; end
      for (int k = 0; k < 6; k++) begin s2[k] = '0; a2[k] = '0; end

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_dout", 64'(delay_out), 64'(0));
      chk("rst_ready", 64'(cfg_ready), 64'(1));
      chk("rst_settling", 64'(settling), 64'(0));
      chk("rst_ovalid", 64'(out_valid), 64'(0));
      chk("rst_err", 64'(cfg_err), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // 1: basic commit, tick every 4 clk
      wr(0, 5); wr(3, 12); wr(7, 63);
      cmt();
      chk("t1_armed_ready", 64'(cfg_ready), 64'(0));
      repeat (2) @(negedge clk);
      chk("t1_pre_dout", 64'(delay_out), 64'(0));
      xfer("t1");
      repeat (3) @(negedge clk);
      settle(64, 3, "t1");

      // 2: clamp and invalid channel on the 6-channel instance
      wr(2, 63);
      chk("t2_err_valid_ch", 64'(cfg_err2), 64'(0));
      wr(7, 9);
      chk("t2_err_pulse", 64'(cfg_err2), 64'(1));
      chk("t2_err_dut1", 64'(cfg_err), 64'(0));
      @(negedge clk);
      chk("t2_err_once", 64'(cfg_err2), 64'(0));
      cmt();
      xfer("t2");
      chk("t2_clamp_dout2", 64'(delay_out2), 64'(pk6()));
      settle(64, 0, "t2");

      // 3: atomicity
      for (int k = 0; k < 8; k++) wr(k, 10 + 3*k);
      cmt();
      repeat (100) @(negedge clk);
      chk("t3_armed_dout", 64'(delay_out), 64'(pk8()));
      chk("t3_armed_ready", 64'(cfg_ready), 64'(0));
      chk("t3_armed_settling", 64'(settling), 64'(0));
      xfer("t3");
      chk("t3_dout2", 64'(delay_out2), 64'(pk6()));
      settle(32, 0, "t3");

      // 4a: write and commit in the same cycle
      wr(5, 50, 1'b1);
      chk("t4a_ready", 64'(cfg_ready), 64'(0));
      xfer("t4a");
      settle(51, 0, "t4a");

      // 4b: commit coincident with tick in IDLE
      wr(1, 2);
      commit = 1'b1; sample_tick = 1'b1;
      @(negedge clk);
      commit = 1'b0; sample_tick = 1'b0;
      chk("t4b_no_xfer", 64'(delay_out), 64'(pk8()));
      chk("t4b_settling", 64'(settling), 64'(0));
      chk("t4b_armed", 64'(cfg_ready), 64'(0));
      repeat (2) @(negedge clk);
      xfer("t4b");
      settle(51, 0, "t4b");

      // 5: re-commit during SETTLE
      for (int k = 0; k < 8; k++) wr(k, (k == 0) ? 30 : k);
      cmt();
      xfer("t5a");
      for (int i = 0; i < 10; i++) begin
         tick(0);
         chk("t5_hold10", 64'(settling), 64'(1));
      end
      wr(1, 3);
      chk("t5_wr_settling", 64'(settling), 64'(1));
      cmt();
      chk("t5_cmt_settling", 64'(settling), 64'(1));
      chk("t5_cmt_ready", 64'(cfg_ready), 64'(0));
      @(negedge clk);
      chk("t5_armed_ovalid", 64'(out_valid), 64'(0));
      xfer("t5b");
      settle(31, 0, "t5b");

      // 6: asynchronous reset mid-settle
      wr(0, 20);
      cmt();
      xfer("t6a");
      repeat (3) tick(0);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_dout", 64'(delay_out), 64'(0));
      chk("t6_rst_settling", 64'(settling), 64'(0));
      chk("t6_rst_ovalid", 64'(out_valid), 64'(0));
      chk("t6_rst_ready", 64'(cfg_ready), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin s[k] = '0; a[k] = '0; end
      for (int k = 0; k < 6; k++) begin s2[k] = '0; a2[k] = '0; end
      for (int i = 0; i < 5; i++) begin
         tick(0);
         chk("t6_ovalid_low", 64'(out_valid), 64'(0));
      end
      cmt();
      xfer("t6b");
      settle(1, 0, "t6b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
